// File: rtl/hs32_fetch.sv
// hs32_fetch -- instruction fetch stage for the HS32 core.
//
// Fetches 32-bit words from the memory arbiter at a sequential program
// counter and queues {fetch address, instruction} pairs in a small FIFO.
// The decode stage drains the FIFO through a valid/ready handshake. Execute
// redirects fetch with a one-cycle flush pulse carrying the new target.
//
// Ports:
//   clk    in   system clock, rising-edge active
//   reset  in   synchronous active-low reset
//   newpc  in   redirect target, qualified by flush
//   flush  in   one-cycle redirect pulse
//   addr   out  memory fetch address (registered)
//   dtrm   in   memory read data, qualified by rdym
//   reqm   out  memory read request (registered)
//   rdym   in   memory data valid
//   instd  out  instruction at FIFO head
//   pcd    out  address of instd
//   reqd   out  FIFO non-empty (registered)
//   rdyd   in   decode accepts head; pop on reqd && rdyd
module hs32_fetch #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] newpc,
  input  logic        flush,
  output logic [31:0] addr,
  input  logic [31:0] dtrm,
  output logic        reqm,
  input  logic        rdym,
  output logic [31:0] instd,
  output logic [31:0] pcd,
  output logic        reqd,
  input  logic        rdyd
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // DRAIN waits out a request that was overtaken by a flush; the arbiter
  // cannot abort it, so its data is simply thrown away on arrival.
  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t         state, state_d;
  logic [31:0]    pc, pc_d, addr_d;
  logic           reqm_d;
  logic [CW-1:0]  count, count_d;
  logic [PW-1:0]  wptr, rptr;
  logic [63:0]    fifo [DEPTH];
  logic           push, pop;

  // A flush cancels any pop in the same cycle along with the FIFO contents.
  assign pop = reqd && rdyd && !flush;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    addr_d  = addr;
    reqm_d  = reqm;
    push    = 1'b0;

    unique case (state)
      IDLE: begin
        if (flush) begin
          state_d = FETCH;
          addr_d  = newpc;
          reqm_d  = 1'b1;
        end else if (count < CW'(DEPTH)) begin
          // Pre-pop count: an in-flight request can then never overfill.
          state_d = FETCH;
          addr_d  = pc;
          reqm_d  = 1'b1;
        end
      end
      FETCH: begin
        if (rdym) begin
          state_d = IDLE;
          reqm_d  = 1'b0;
          if (!flush) begin
            push = 1'b1;
            pc_d = addr + 32'd4;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rdym) begin
          state_d = IDLE;
          reqm_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // The latest redirect always wins, whatever the request state.
    if (flush) pc_d = newpc;
  end

  always_comb begin
    count_d = count;
    if (flush)
      count_d = '0;
    else if (push && !pop)
      count_d = count + CW'(1);
    else if (pop && !push)
      count_d = count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      addr  <= RESET_PC;
      reqm  <= 1'b0;
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      reqd  <= 1'b0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      addr  <= addr_d;
      reqm  <= reqm_d;
      count <= count_d;
      reqd  <= (count_d != '0);
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
      end
    end
  end

  // NOTE: the storage is reset only because the head must read as zero
  // before the first push; with a tiny DEPTH this costs just a few flops'
  // worth of reset fan-out. A larger FIFO would use a valid flag instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) fifo[i] <= '0;
    end else if (push) begin
      fifo[wptr] <= {addr, dtrm};
    end
  end

  assign pcd   = fifo[rptr][63:32];
  assign instd = fifo[rptr][31:0];

endmodule
